// File: rtl/regfile_pkg.sv
// Shared defaults and source encoding for the register-file writeback arbiter.
package regfile_pkg;

  localparam int REG_AW_DEF = 5;
  localparam int DATA_W_DEF = 32;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } src_e;

endpackage

// File: rtl/wb_scoreboard.sv
// Destination scoreboard: tracks registers reserved at issue and awaiting writeback,
// and answers the source-operand hazard queries.
module wb_scoreboard
  import regfile_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   alloc_valid,
  output logic                   alloc_ready,
  input  logic [REG_AW-1:0]      alloc_dst,
  input  logic                   wr_en,
  input  logic [REG_AW-1:0]      wr_dst,
  input  logic [REG_AW-1:0]      AA,
  input  logic [REG_AW-1:0]      BA,
  output logic                   hazard_a,
  output logic                   hazard_b,
  output logic [(1<<REG_AW)-1:0] pending
);

  localparam int NREGS = 1 << REG_AW;

  logic             alloc_fire;
  logic [NREGS-1:0] set_mask;
  logic [NREGS-1:0] clr_mask;

  assign alloc_ready = !rst && !((alloc_dst != '0) && pending[alloc_dst]);
  assign alloc_fire  = alloc_valid && alloc_ready && (alloc_dst != '0);

  // NOTE: every signal driven in always_comb gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (alloc_fire) set_mask[alloc_dst] = 1'b1;
    if (wr_en)      clr_mask[wr_dst]    = 1'b1;
  end

  // Set is applied after clear so a same-edge reservation survives the retiring write.
  // NOTE: state is updated with non-blocking assignments only; reset is synchronous and sampled on the edge.
  always_ff @(posedge clk) begin
    if (rst) pending <= '0;
    else     pending <= (pending & ~clr_mask) | set_mask;
  end

  // A write landing this cycle already resolves the hazard, so it is bypassed out.
  assign hazard_a = pending[AA] && (AA != '0) && !(wr_en && (wr_dst == AA));
  assign hazard_b = pending[BA] && (BA != '0) && !(wr_en && (wr_dst == BA));

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates ALU and load writebacks onto one registered register-file write port.
// Define WBARB_RR_EN for round-robin conflict resolution; otherwise loads win every conflict.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   alu_valid,
  output logic                   alu_ready,
  input  logic [REG_AW-1:0]      alu_dst,
  input  logic [DATA_W-1:0]      alu_data,
  input  logic                   mem_valid,
  output logic                   mem_ready,
  input  logic [REG_AW-1:0]      mem_dst,
  input  logic [DATA_W-1:0]      mem_data,
  input  logic                   alloc_valid,
  output logic                   alloc_ready,
  input  logic [REG_AW-1:0]      alloc_dst,
  input  logic [REG_AW-1:0]      AA,
  input  logic [REG_AW-1:0]      BA,
  output logic                   hazard_a,
  output logic                   hazard_b,
  output logic                   RW,
  output logic [REG_AW-1:0]      DA,
  output logic [DATA_W-1:0]      BUS_D,
  output logic [(1<<REG_AW)-1:0] pending
);

  logic              grant_any;
  src_e              grant_src;
  logic [REG_AW-1:0] sel_dst;
  logic [DATA_W-1:0] sel_data;
  logic              do_write;

`ifdef WBARB_RR_EN
  src_e rr_ptr;
  logic conflict;

  assign conflict = !rst && alu_valid && mem_valid;

  always_ff @(posedge clk) begin
    if (rst)           rr_ptr <= SRC_ALU;
    else if (conflict) rr_ptr <= (rr_ptr == SRC_ALU) ? SRC_MEM : SRC_ALU;
  end
`endif

  always_comb begin
    grant_any = 1'b0;
    grant_src = SRC_ALU;
    if (!rst) begin
      if (alu_valid && mem_valid) begin
        grant_any = 1'b1;
`ifdef WBARB_RR_EN
        grant_src = rr_ptr;
`else
        grant_src = SRC_MEM;
`endif
      end else if (alu_valid) begin
        grant_any = 1'b1;
        grant_src = SRC_ALU;
      end else if (mem_valid) begin
        grant_any = 1'b1;
        grant_src = SRC_MEM;
      end
    end
  end

  assign alu_ready = grant_any && (grant_src == SRC_ALU);
  assign mem_ready = grant_any && (grant_src == SRC_MEM);

  assign sel_dst  = (grant_src == SRC_MEM) ? mem_dst  : alu_dst;
  assign sel_data = (grant_src == SRC_MEM) ? mem_data : alu_data;

  // R0 writes still handshake but never reach the port.
  assign do_write = grant_any && (sel_dst != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      RW    <= 1'b0;
      DA    <= '0;
      BUS_D <= '0;
    end else begin
      RW <= do_write;
      if (do_write) begin
        DA    <= sel_dst;
        BUS_D <= sel_data;
      end
    end
  end

  wb_scoreboard #(
    .REG_AW (REG_AW)
  ) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .alloc_valid (alloc_valid),
    .alloc_ready (alloc_ready),
    .alloc_dst   (alloc_dst),
    .wr_en       (RW),
    .wr_dst      (DA),
    .AA          (AA),
    .BA          (BA),
    .hazard_a    (hazard_a),
    .hazard_b    (hazard_b),
    .pending     (pending)
  );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter; expectations follow the WBARB_RR_EN setting.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_dst;
  logic [31:0] alu_data;
  logic        mem_valid, mem_ready;
  logic [4:0]  mem_dst;
  logic [31:0] mem_data;
  logic        alloc_valid, alloc_ready;
  logic [4:0]  alloc_dst;
  logic [4:0]  AA, BA;
  logic        hazard_a, hazard_b;
  logic        RW;
  logic [4:0]  DA;
  logic [31:0] BUS_D;
  logic [31:0] pending;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_dst(alu_dst), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_dst(mem_dst), .mem_data(mem_data),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_dst(alloc_dst),
    .AA(AA), .BA(BA), .hazard_a(hazard_a), .hazard_b(hazard_b),
    .RW(RW), .DA(DA), .BUS_D(BUS_D), .pending(pending)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    alu_valid = 1'b1; alu_dst = 5'd1; alu_data = 32'h1;
    mem_valid = 1'b1; mem_dst = 5'd2; mem_data = 32'h2;
    alloc_valid = 1'b1; alloc_dst = 5'd3;
    AA = 5'd0; BA = 5'd0;
    tick();
    tick();
    n_cmp++; if (alu_ready !== 1'b0) begin n_bad++; $display("FAIL reset_alu_ready got %b want 0", alu_ready); end
    n_cmp++; if (mem_ready !== 1'b0) begin n_bad++; $display("FAIL reset_mem_ready got %b want 0", mem_ready); end
    n_cmp++; if (alloc_ready !== 1'b0) begin n_bad++; $display("FAIL reset_alloc_ready got %b want 0", alloc_ready); end
    n_cmp++; if (RW !== 1'b0) begin n_bad++; $display("FAIL reset_rw got %b want 0", RW); end
    n_cmp++; if (DA !== 5'd0) begin n_bad++; $display("FAIL reset_da got %0d want 0", DA); end
    n_cmp++; if (BUS_D !== 32'h0) begin n_bad++; $display("FAIL reset_bus_d got %h want 0", BUS_D); end
    n_cmp++; if (pending !== 32'h0) begin n_bad++; $display("FAIL reset_pending got %h want 0", pending); end
    alu_valid = 1'b0; mem_valid = 1'b0; alloc_valid = 1'b0;
    rst = 1'b0;
    tick();
    n_cmp++; if (RW !== 1'b0) begin n_bad++; $display("FAIL post_reset_rw got %b want 0", RW); end
  endtask

  task automatic test_alu_write();
    alu_valid = 1'b1; alu_dst = 5'd5; alu_data = 32'hDEADBEEF;
    #1;
    n_cmp++; if (alu_ready !== 1'b1) begin n_bad++; $display("FAIL alu_ready got %b want 1", alu_ready); end
    n_cmp++; if (mem_ready !== 1'b0) begin n_bad++; $display("FAIL alu_only_mem_ready got %b want 0", mem_ready); end
    tick();
    alu_valid = 1'b0;
    #1;
    n_cmp++; if (RW !== 1'b1) begin n_bad++; $display("FAIL alu_rw got %b want 1", RW); end
    n_cmp++; if (DA !== 5'd5) begin n_bad++; $display("FAIL alu_da got %0d want 5", DA); end
    n_cmp++; if (BUS_D !== 32'hDEADBEEF) begin n_bad++; $display("FAIL alu_bus_d got %h want deadbeef", BUS_D); end
    n_cmp++; if (alu_ready !== 1'b0) begin n_bad++; $display("FAIL alu_ready_idle got %b want 0", alu_ready); end
    tick();
    n_cmp++; if (RW !== 1'b0) begin n_bad++; $display("FAIL alu_rw_after got %b want 0", RW); end
    n_cmp++; if (DA !== 5'd5) begin n_bad++; $display("FAIL alu_da_hold got %0d want 5", DA); end
  endtask

  task automatic test_conflict();
    logic       exp_mem;
    logic [4:0] exp_dst;
    alu_valid = 1'b1; alu_dst = 5'd3; alu_data = 32'hAAAA0003;
    mem_valid = 1'b1; mem_dst = 5'd4; mem_data = 32'hBBBB0004;
    for (int i = 0; i < 4; i++) begin
`ifdef WBARB_RR_EN
      exp_mem = (i % 2) == 1;
`else
      exp_mem = 1'b1;
`endif
      exp_dst = exp_mem ? 5'd4 : 5'd3;
      #1;
      n_cmp++; if (alu_ready !== !exp_mem) begin n_bad++; $display("FAIL conflict%0d_alu_ready got %b want %b", i, alu_ready, !exp_mem); end
      n_cmp++; if (mem_ready !== exp_mem) begin n_bad++; $display("FAIL conflict%0d_mem_ready got %b want %b", i, mem_ready, exp_mem); end
      tick();
      n_cmp++; if (RW !== 1'b1 || DA !== exp_dst) begin n_bad++; $display("FAIL conflict%0d_write got RW=%b DA=%0d want RW=1 DA=%0d", i, RW, DA, exp_dst); end
      n_cmp++; if (BUS_D !== (exp_mem ? 32'hBBBB0004 : 32'hAAAA0003)) begin n_bad++; $display("FAIL conflict%0d_bus_d got %h", i, BUS_D); end
    end
    alu_valid = 1'b0; mem_valid = 1'b0;
    tick();
  endtask

  task automatic test_scoreboard();
    alloc_valid = 1'b1; alloc_dst = 5'd7;
    #1;
    n_cmp++; if (alloc_ready !== 1'b1) begin n_bad++; $display("FAIL alloc7_ready got %b want 1", alloc_ready); end
    tick();
    alloc_valid = 1'b0; AA = 5'd7; BA = 5'd7;
    #1;
    n_cmp++; if (pending !== 32'h0000_0080) begin n_bad++; $display("FAIL alloc7_pending got %h want 00000080", pending); end
    n_cmp++; if (hazard_a !== 1'b1) begin n_bad++; $display("FAIL hazard_a7 got %b want 1", hazard_a); end
    n_cmp++; if (hazard_b !== 1'b1) begin n_bad++; $display("FAIL hazard_b7 got %b want 1", hazard_b); end
    AA = 5'd0;
    #1;
    n_cmp++; if (hazard_a !== 1'b0) begin n_bad++; $display("FAIL hazard_a_r0 got %b want 0", hazard_a); end
    AA = 5'd7;
    alloc_valid = 1'b1; alloc_dst = 5'd7;
    #1;
    n_cmp++; if (alloc_ready !== 1'b0) begin n_bad++; $display("FAIL realloc7_ready got %b want 0", alloc_ready); end
    tick();
    alloc_valid = 1'b0;
    mem_valid = 1'b1; mem_dst = 5'd7; mem_data = 32'h0000_7777;
    #1;
    n_cmp++; if (mem_ready !== 1'b1) begin n_bad++; $display("FAIL mem7_ready got %b want 1", mem_ready); end
    tick();
    mem_valid = 1'b0;
    #1;
    n_cmp++; if (RW !== 1'b1 || DA !== 5'd7) begin n_bad++; $display("FAIL mem7_write got RW=%b DA=%0d want RW=1 DA=7", RW, DA); end
    n_cmp++; if (hazard_a !== 1'b0) begin n_bad++; $display("FAIL hazard_a_bypass got %b want 0", hazard_a); end
    n_cmp++; if (pending[7] !== 1'b1) begin n_bad++; $display("FAIL pending7_during_write got %b want 1", pending[7]); end
    tick();
    n_cmp++; if (pending !== 32'h0) begin n_bad++; $display("FAIL pending7_cleared got %h want 0", pending); end
    n_cmp++; if (hazard_a !== 1'b0 || hazard_b !== 1'b0) begin n_bad++; $display("FAIL hazards_cleared got a=%b b=%b want 0 0", hazard_a, hazard_b); end
    AA = 5'd0; BA = 5'd0;
  endtask

  task automatic test_dst_zero();
    alu_valid = 1'b1; alu_dst = 5'd0; alu_data = 32'h1234_5678;
    #1;
    n_cmp++; if (alu_ready !== 1'b1) begin n_bad++; $display("FAIL dst0_ready got %b want 1", alu_ready); end
    tick();
    alu_valid = 1'b0;
    #1;
    n_cmp++; if (RW !== 1'b0) begin n_bad++; $display("FAIL dst0_rw got %b want 0", RW); end
    n_cmp++; if (pending !== 32'h0) begin n_bad++; $display("FAIL dst0_pending got %h want 0", pending); end
    alloc_valid = 1'b1; alloc_dst = 5'd0;
    tick();
    alloc_valid = 1'b0;
    n_cmp++; if (pending !== 32'h0) begin n_bad++; $display("FAIL alloc0_pending got %h want 0", pending); end
  endtask

  task automatic test_set_wins();
    mem_valid = 1'b1; mem_dst = 5'd9; mem_data = 32'h0000_0009;
    tick();
    mem_valid = 1'b0;
    alloc_valid = 1'b1; alloc_dst = 5'd9;
    #1;
    n_cmp++; if (RW !== 1'b1 || DA !== 5'd9) begin n_bad++; $display("FAIL set_wins_write got RW=%b DA=%0d want RW=1 DA=9", RW, DA); end
    n_cmp++; if (alloc_ready !== 1'b1) begin n_bad++; $display("FAIL set_wins_alloc_ready got %b want 1", alloc_ready); end
    tick();
    alloc_valid = 1'b0;
    n_cmp++; if (pending !== 32'h0000_0200) begin n_bad++; $display("FAIL set_wins_pending got %h want 00000200", pending); end
  endtask

  task automatic test_reset_midflight();
    alu_valid = 1'b1; alu_dst = 5'd12; alu_data = 32'hCAFE_000C;
    tick();
    rst = 1'b1;
    mem_valid = 1'b1; mem_dst = 5'd13; mem_data = 32'h0000_000D;
    alloc_valid = 1'b1; alloc_dst = 5'd15;
    #1;
    n_cmp++; if (alu_ready !== 1'b0 || mem_ready !== 1'b0 || alloc_ready !== 1'b0) begin n_bad++; $display("FAIL midrst_readys got alu=%b mem=%b alloc=%b want 0 0 0", alu_ready, mem_ready, alloc_ready); end
    tick();
    n_cmp++; if (RW !== 1'b0) begin n_bad++; $display("FAIL midrst_rw got %b want 0", RW); end
    n_cmp++; if (pending !== 32'h0) begin n_bad++; $display("FAIL midrst_pending got %h want 0", pending); end
    n_cmp++; if (DA !== 5'd0 || BUS_D !== 32'h0) begin n_bad++; $display("FAIL midrst_port got DA=%0d BUS_D=%h want 0 0", DA, BUS_D); end
    rst = 1'b0;
    alu_valid = 1'b0; mem_valid = 1'b0; alloc_valid = 1'b0;
    tick();
    n_cmp++; if (RW !== 1'b0) begin n_bad++; $display("FAIL midrst_after_rw got %b want 0", RW); end
  endtask

  initial begin
    test_reset();
    test_alu_write();
    test_conflict();
    test_scoreboard();
    test_dst_zero();
    test_set_wins();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter REG_AW, default 5: register address width (32 registers).
REQ-002 SHALL have parameter DATA_W, default 32: write data width.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have ports alu_valid (in, 1), alu_ready (out, 1), alu_dst (in, 5) and alu_data (in, 32): the ALU writeback request.
REQ-006 SHALL have ports mem_valid (in, 1), mem_ready (out, 1), mem_dst (in, 5) and mem_data (in, 32): the load writeback request.
REQ-007 SHALL have ports alloc_valid (in, 1), alloc_ready (out, 1) and alloc_dst (in, 5): issue-stage destination reservation.
REQ-008 SHALL have ports AA (in, 5), BA (in, 5), hazard_a (out, 1) and hazard_b (out, 1): source-operand hazard query.
REQ-009 SHALL have ports RW (out, 1), DA (out, 5) and BUS_D (out, 32): the register-file write port, all registered.
REQ-010 SHALL have port pending, output, 32: scoreboard bitmap, bit n = register n awaiting writeback.

Function
REQ-011 SHALL complete a handshake on a source when its valid and ready are both high in the same cycle.
REQ-012 SHALL grant at most one source per cycle; the ungranted source's ready SHALL be low.
REQ-013 SHALL drive the granted source's ready high only while that source is valid.
REQ-014 SHALL, when exactly one source is valid, grant that source.
REQ-015 SHALL, when both sources are valid, resolve the conflict per REQ-027/REQ-028.
REQ-016 SHALL register the granted dst/data onto DA/BUS_D with RW=1 exactly one cycle after the handshake (latency 1); otherwise RW=0 and DA/BUS_D hold their last value.
REQ-017 SHALL, for a granted write with dst 0, complete the handshake but drive RW=0 on the next cycle (R0 is never written).
REQ-018 SHALL, on alloc_valid & alloc_ready, set pending[alloc_dst] at the next edge; alloc_dst 0 SHALL never set a bit.
REQ-019 SHALL drive alloc_ready low combinationally when alloc_dst≠0 and pending[alloc_dst]=1; otherwise high.
REQ-020 SHALL clear pending[DA] at the edge ending a cycle in which RW=1.
REQ-021 SHALL, when a set and a clear target the same register at the same edge, leave the bit set (the set wins).
REQ-022 SHALL compute hazard_a = pending[AA] & (AA≠0) & ~(RW & DA==AA) combinationally; hazard_b likewise from BA.
REQ-023 SHALL leave source-side data stable requirements to the requester: dst/data SHALL be held until the handshake completes.

Reset
REQ-024 SHALL, with rst high at a clock edge, set pending=0, RW=0, DA=0, BUS_D=0 and the round-robin pointer to ALU.
REQ-025 SHALL, while rst is high, drive alu_ready=0, mem_ready=0 and alloc_ready=0.
REQ-026 SHALL drop any handshake in flight when rst is asserted; no write SHALL appear on RW in the cycle after reset deasserts.

Configuration
REQ-027 SHALL, with macro WBARB_RR_EN defined, resolve simultaneous requests round-robin: a 1-bit pointer names the preferred source and toggles to the other source after each granted conflict.
REQ-028 SHALL, with WBARB_RR_EN undefined, grant mem over alu on every conflict and omit the pointer register.

Structure
REQ-029 SHALL take REG_AW/DATA_W defaults and the source-index encoding (SRC_ALU=0, SRC_MEM=1) from the shared package regfile_pkg.
REQ-030 SHALL instantiate one sub-module, wb_scoreboard, holding pending, alloc_ready and hazard_a/hazard_b; arbitration and output registers SHALL stay in the top module.

Verification
REQ-031 SHALL pass: alu_valid with dst=5, data=0xDEADBEEF, alone → alu_ready=1; next cycle RW=1, DA=5, BUS_D=0xDEADBEEF.
REQ-032 SHALL pass: both sources valid for 4 cycles (dst 3/dst 4) with WBARB_RR_EN → grants alternate alu, mem, alu, mem; without WBARB_RR_EN → mem granted every cycle while it stays valid.
REQ-033 SHALL pass: alloc dst=7, then AA=7 → hazard_a=1 and a second alloc of 7 sees alloc_ready=0; mem write to 7 → hazard_a=0 in the RW=1 cycle; pending[7]=0 on the following cycle.
REQ-034 SHALL pass: alu write to dst 0 → handshake completes, RW stays 0, pending unchanged.
REQ-035 SHALL pass: RW=1 with DA=9 at the same edge as alloc of 9 → pending[9]=1 afterward.
REQ-036 SHALL pass: rst asserted the cycle after a handshake → RW=0, pending=0, all readys low during reset.
